// File: rtl/ads_irq_pio_pkg.sv
// rtl/ads_irq_pio_pkg.sv - register map and edge-select constants for the input PIO
package ads_pio_pkg;

    typedef enum logic [1:0] {
        ADDR_DATA    = 2'd0,
        ADDR_RSVD    = 2'd1,
        ADDR_IRQMASK = 2'd2,
        ADDR_EDGECAP = 2'd3
    } pio_addr_e;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

endpackage

// File: rtl/ads_irq_pio_if.sv
// rtl/ads_irq_pio_if.sv - Avalon-MM slave bus bundle for the input PIO
interface ads_irq_pio_if #(
    parameter int WIDTH = 1
);
    logic [1:0]       address;
    logic             chipselect;
    logic             write_n;
    logic [WIDTH-1:0] writedata;
    logic [WIDTH-1:0] readdata;

    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/ads_irq_pio_debounce_ch.sv
// rtl/ads_irq_pio_debounce_ch.sv - one channel: 2-flop sync, debounce counter, stable/prev and edge strobes
module ads_debounce_ch #(
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter bit IDLE_LEVEL      = 1'b1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic in_i,
    output logic stable_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
    localparam logic [CW-1:0] CNT_LAST = (DEBOUNCE_CYCLES > 0) ? CW'(DEBOUNCE_CYCLES - 1) : '0;

    logic          s1_q, s2_q;
    logic          stable_q, stable_d;
    logic          prev_q;
    logic [CW-1:0] cnt_q, cnt_d;

    // Any return of s2 to the accepted level drops the count, so short glitches never land.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (DEBOUNCE_CYCLES == 0) begin
            stable_d = s2_q;
        end else if (s2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = s2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q     <= IDLE_LEVEL;
            s2_q     <= IDLE_LEVEL;
            stable_q <= IDLE_LEVEL;
            prev_q   <= IDLE_LEVEL;
            cnt_q    <= '0;
        end else begin
            s1_q     <= in_i;
            s2_q     <= s1_q;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            cnt_q    <= cnt_d;
        end
    end

    assign stable_o = stable_q;
    assign rise_o   = stable_q & ~prev_q;
    assign fall_o   = ~stable_q & prev_q;

endmodule

// File: rtl/ads_irq_pio.sv
// rtl/ads_irq_pio.sv - debounced input PIO with sticky edge capture and maskable level irq
module ads_irq_pio
    import ads_pio_pkg::*;
#(
    parameter int WIDTH           = 1,
    parameter int DEBOUNCE_CYCLES = 1000,
    parameter int EDGE_TYPE       = 1,
    parameter bit IDLE_LEVEL      = 1'b1
) (
    input  logic             clk,
    input  logic             reset_n,
    ads_irq_pio_if.slave     bus,
    input  logic [WIDTH-1:0] in_port,
    output logic             irq
);
    logic [WIDTH-1:0] stable, rise, fall, evt;
    logic [WIDTH-1:0] irqmask_q, irqmask_d;
    logic [WIDTH-1:0] edgecap_q, edgecap_d;
    logic [WIDTH-1:0] readdata_q, readdata_d;
    logic             wr;

    for (genvar i = 0; i < WIDTH; i++) begin : g_ch
        ads_debounce_ch #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .IDLE_LEVEL     (IDLE_LEVEL)
        ) u_ch (
            .clk     (clk),
            .reset_n (reset_n),
            .in_i    (in_port[i]),
            .stable_o(stable[i]),
            .rise_o  (rise[i]),
            .fall_o  (fall[i])
        );
    end

    if (EDGE_TYPE == EDGE_RISE) begin : g_rise
        assign evt = rise;
    end else if (EDGE_TYPE == EDGE_FALL) begin : g_fall
        assign evt = fall;
    end else begin : g_any
        assign evt = rise | fall;
    end

    assign wr = bus.chipselect & ~bus.write_n;

    // The event OR is applied after the clear so a same-cycle edge keeps its bit set.
    always_comb begin
        irqmask_d = irqmask_q;
        edgecap_d = edgecap_q;
        if (wr && bus.address == ADDR_IRQMASK) irqmask_d = bus.writedata;
        if (wr && bus.address == ADDR_EDGECAP) edgecap_d = edgecap_q & ~bus.writedata;
        edgecap_d = edgecap_d | evt;
        case (pio_addr_e'(bus.address))
            ADDR_DATA:    readdata_d = stable;
            ADDR_IRQMASK: readdata_d = irqmask_q;
            ADDR_EDGECAP: readdata_d = edgecap_q;
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    assign bus.readdata = readdata_q;
    assign irq          = |(edgecap_q & irqmask_q);

endmodule

// File: tb/tb_ads_irq_pio.sv
// tb/tb_ads_irq_pio.sv - three PIO instances (rise/fall/any) checked against a read scoreboard
module tb_ads_irq_pio;
    import ads_pio_pkg::*;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [1:0] address = 2'd0;
    logic       chipselect = 1'b0;
    logic       write_n = 1'b1;
    logic [3:0] writedata = 4'h0;
    logic [3:0] in_port = 4'hF;
    logic       irq_r, irq_f, irq_a;

    always #5 clk = ~clk;

    ads_irq_pio_if #(.WIDTH(4)) bus_r ();
    ads_irq_pio_if #(.WIDTH(4)) bus_f ();
    ads_irq_pio_if #(.WIDTH(4)) bus_a ();

    assign bus_r.address = address; assign bus_r.chipselect = chipselect;
    assign bus_r.write_n = write_n; assign bus_r.writedata = writedata;
    assign bus_f.address = address; assign bus_f.chipselect = chipselect;
    assign bus_f.write_n = write_n; assign bus_f.writedata = writedata;
    assign bus_a.address = address; assign bus_a.chipselect = chipselect;
    assign bus_a.write_n = write_n; assign bus_a.writedata = writedata;

    ads_irq_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(EDGE_RISE), .IDLE_LEVEL(1'b1)) dut_r (
        .clk(clk), .reset_n(reset_n), .bus(bus_r), .in_port(in_port), .irq(irq_r));
    ads_irq_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(EDGE_FALL), .IDLE_LEVEL(1'b1)) dut_f (
        .clk(clk), .reset_n(reset_n), .bus(bus_f), .in_port(in_port), .irq(irq_f));
    ads_irq_pio #(.WIDTH(4), .DEBOUNCE_CYCLES(8), .EDGE_TYPE(EDGE_ANY), .IDLE_LEVEL(1'b1)) dut_a (
        .clk(clk), .reset_n(reset_n), .bus(bus_a), .in_port(in_port), .irq(irq_a));

    // Readback order everywhere: {falling, rising, any}
    wire [11:0] rd_all  = {bus_f.readdata, bus_r.readdata, bus_a.readdata};
    wire [2:0]  irq_all = {irq_f, irq_r, irq_a};

    typedef struct {
        logic [1:0]  addr;
        logic [11:0] exp;
        string       name;
    } rd_t;

    rd_t sb[$];
    int  vectors = 0;
    int  miscompares = 0;

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic bus_write(input logic [1:0] a, input logic [3:0] d);
        address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic bus_read(input logic [1:0] a, output logic [11:0] got);
        address = a;
        @(negedge clk);
        got = rd_all;
    endtask

    task automatic expect_rd(input logic [1:0] a, input logic [11:0] exp, input string name);
        sb.push_back('{addr: a, exp: exp, name: name});
    endtask

    task automatic test_reset();
        rd_t e; logic [11:0] got;
        reset_n = 1'b0; in_port = 4'hF;
        tick(2);
        vectors++;
        if (rd_all !== 12'h000 || irq_all !== 3'b000) begin
            $display("FAIL in_reset: readdata %h irq %b, want 000/000", rd_all, irq_all); miscompares++;
        end
        reset_n = 1'b1;
        expect_rd(ADDR_DATA, 12'hFFF, "reset_data");
        expect_rd(ADDR_IRQMASK, 12'h000, "reset_irqmask");
        expect_rd(ADDR_EDGECAP, 12'h000, "reset_edgecap");
        expect_rd(ADDR_RSVD, 12'h000, "reset_rsvd");
        while (sb.size() > 0) begin
            e = sb.pop_front(); bus_read(e.addr, got); vectors++;
            if (got !== e.exp) begin
                $display("FAIL %s: got %h want %h", e.name, got, e.exp); miscompares++;
            end
        end
        vectors++;
        if (irq_all !== 3'b000) begin
            $display("FAIL reset_irq: got %b want 000", irq_all); miscompares++;
        end
    endtask

    task automatic test_debounce();
        rd_t e; logic [11:0] got;
        in_port = 4'hE; tick(5); in_port = 4'hF; tick(20);
        expect_rd(ADDR_EDGECAP, 12'h000, "glitch_edgecap");
        expect_rd(ADDR_DATA, 12'hFFF, "glitch_data");
        while (sb.size() > 0) begin
            e = sb.pop_front(); bus_read(e.addr, got); vectors++;
            if (got !== e.exp) begin
                $display("FAIL %s: got %h want %h", e.name, got, e.exp); miscompares++;
            end
        end
        // Edge capture lands on the 11th edge after the change; readdata shows it one edge later.
        address = ADDR_EDGECAP;
        in_port = 4'hE;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (k == 11) begin
                vectors++;
                if (rd_all !== 12'h000) begin
                    $display("FAIL capture_early: got %h want 000", rd_all); miscompares++;
                end
            end
            if (k == 12) begin
                vectors++;
                if (rd_all !== 12'h101) begin
                    $display("FAIL capture_at_11: got %h want 101", rd_all); miscompares++;
                end
            end
        end
        tick(8);
        expect_rd(ADDR_DATA, 12'hEEE, "low_data");
        expect_rd(ADDR_EDGECAP, 12'h101, "low_edgecap");
        while (sb.size() > 0) begin
            e = sb.pop_front(); bus_read(e.addr, got); vectors++;
            if (got !== e.exp) begin
                $display("FAIL %s: got %h want %h", e.name, got, e.exp); miscompares++;
            end
        end
        in_port = 4'hF; tick(20);
        expect_rd(ADDR_DATA, 12'hFFF, "release_data");
        expect_rd(ADDR_EDGECAP, 12'h111, "release_edgecap");
        while (sb.size() > 0) begin
            e = sb.pop_front(); bus_read(e.addr, got); vectors++;
            if (got !== e.exp) begin
                $display("FAIL %s: got %h want %h", e.name, got, e.exp); miscompares++;
            end
        end
    endtask

    task automatic test_irq_mask();
        rd_t e; logic [11:0] got;
        vectors++;
        if (irq_all !== 3'b000) begin
            $display("FAIL irq_masked: got %b want 000", irq_all); miscompares++;
        end
        bus_write(ADDR_IRQMASK, 4'h1);
        vectors++;
        if (irq_all !== 3'b111) begin
            $display("FAIL irq_unmask: got %b want 111", irq_all); miscompares++;
        end
        bus_write(ADDR_EDGECAP, 4'h1);
        vectors++;
        if (irq_all !== 3'b000) begin
            $display("FAIL irq_clear: got %b want 000", irq_all); miscompares++;
        end
        bus_write(ADDR_DATA, 4'h0);
        bus_write(ADDR_RSVD, 4'hF);
        expect_rd(ADDR_IRQMASK, 12'h111, "mask_readback");
        expect_rd(ADDR_EDGECAP, 12'h000, "w1c_cleared");
        expect_rd(ADDR_DATA, 12'hFFF, "data_ro");
        expect_rd(ADDR_RSVD, 12'h000, "rsvd_ro");
        while (sb.size() > 0) begin
            e = sb.pop_front(); bus_read(e.addr, got); vectors++;
            if (got !== e.exp) begin
                $display("FAIL %s: got %h want %h", e.name, got, e.exp); miscompares++;
            end
        end
    endtask

    task automatic test_w1c_race();
        rd_t e; logic [11:0] got;
        in_port = 4'hD;
        tick(10);
        bus_write(ADDR_EDGECAP, 4'h2);
        vectors++;
        if (irq_all !== 3'b000) begin
            $display("FAIL race_irq_masked: got %b want 000", irq_all); miscompares++;
        end
        expect_rd(ADDR_EDGECAP, 12'h202, "race_edgecap");
        expect_rd(ADDR_DATA, 12'hDDD, "race_data");
        while (sb.size() > 0) begin
            e = sb.pop_front(); bus_read(e.addr, got); vectors++;
            if (got !== e.exp) begin
                $display("FAIL %s: got %h want %h", e.name, got, e.exp); miscompares++;
            end
        end
        in_port = 4'hF; tick(20);
        expect_rd(ADDR_EDGECAP, 12'h222, "race_release");
        while (sb.size() > 0) begin
            e = sb.pop_front(); bus_read(e.addr, got); vectors++;
            if (got !== e.exp) begin
                $display("FAIL %s: got %h want %h", e.name, got, e.exp); miscompares++;
            end
        end
        bus_write(ADDR_EDGECAP, 4'hF);
        expect_rd(ADDR_EDGECAP, 12'h000, "clear_all");
        while (sb.size() > 0) begin
            e = sb.pop_front(); bus_read(e.addr, got); vectors++;
            if (got !== e.exp) begin
                $display("FAIL %s: got %h want %h", e.name, got, e.exp); miscompares++;
            end
        end
    endtask

    task automatic test_reset_mid();
        rd_t e; logic [11:0] got;
        in_port = 4'hE;
        tick(6);
        vectors++;
        if (dut_f.g_ch[0].u_ch.cnt_q !== 4'd4) begin
            $display("FAIL mid_count: got %0d want 4", dut_f.g_ch[0].u_ch.cnt_q); miscompares++;
        end
        reset_n = 1'b0;
        #1;
        vectors++;
        if (dut_f.g_ch[0].u_ch.cnt_q !== 4'd0 || rd_all !== 12'h000 || irq_all !== 3'b000) begin
            $display("FAIL mid_reset: cnt %0d readdata %h irq %b, want 0/000/000",
                     dut_f.g_ch[0].u_ch.cnt_q, rd_all, irq_all);
            miscompares++;
        end
        in_port = 4'hF;
        tick(2);
        reset_n = 1'b1;
        tick(20);
        expect_rd(ADDR_DATA, 12'hFFF, "post_reset_data");
        expect_rd(ADDR_EDGECAP, 12'h000, "post_reset_edgecap");
        expect_rd(ADDR_IRQMASK, 12'h000, "post_reset_mask");
        while (sb.size() > 0) begin
            e = sb.pop_front(); bus_read(e.addr, got); vectors++;
            if (got !== e.exp) begin
                $display("FAIL %s: got %h want %h", e.name, got, e.exp); miscompares++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_debounce();
        test_irq_mask();
        test_w1c_race();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
